memory_controller: RTL and testbench

- Time-multiplexed arbiter that lets four clients share one single-port 128x8 RAM.
- A 2-bit `state` input selects which client owns the RAM in a given cycle.
- The selected client may read or write one byte per cycle.
- Each client has a dedicated registered read-data output.
- Sits between the CPU-side stage logic (four pipeline/phase users) and the memory array of the 8-bit computer.

---
 rtl/memory_pkg.sv | 13 +
 rtl/memory_array.sv | 37 +++
 rtl/memory_controller.sv | 123 ++++++++++++
 tb/tb_memory_controller.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/memory_pkg.sv
// Shared constants and types for the four-client RAM arbiter.
package memory_pkg;

    localparam int ADDR_WIDTH = 7;
    localparam int DATA_WIDTH = 8;
    localparam int NUM_PORTS  = 4;
    localparam int MEM_DEPTH  = 128;

    typedef logic [ADDR_WIDTH-1:0] addr_t;
    typedef logic [DATA_WIDTH-1:0] data_t;
    typedef logic [1:0]            port_sel_t;

endpackage : memory_pkg

// File: rtl/memory_array.sv
// Single-port RAM with synchronous write, asynchronous whole-array clear and a
// combinational read path. The read value is captured one level up in the
// per-client output registers, which gives the one-clock read latency and the
// read-before-write behaviour (the register samples the word before the write
// lands on the same edge).
module memory_array #(
    parameter int ADDR_WIDTH = memory_pkg::ADDR_WIDTH,
    parameter int DATA_WIDTH = memory_pkg::DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] dout
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    // Storage: every word is cleared while rst is high, otherwise one write per edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we) begin
            mem_q[addr] <= din;
        end
    end

    // Read path: word at the current address, zero when no read is requested.
    assign dout = re ? mem_q[addr] : '0;

endmodule : memory_array

// File: rtl/memory_controller.sv
// Time-multiplexed arbiter: `state` picks which of four clients drives the
// single RAM port this cycle; each client owns a registered read-data output
// that only updates when that client is selected, enabled and reading.
module memory_controller #(
    parameter int ADDR_WIDTH = memory_pkg::ADDR_WIDTH,
    parameter int DATA_WIDTH = memory_pkg::DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [1:0]            state,
    input  logic                  read0,
    input  logic                  read1,
    input  logic                  read2,
    input  logic                  read3,
    input  logic                  write0,
    input  logic                  write1,
    input  logic                  write2,
    input  logic                  write3,
    input  logic [ADDR_WIDTH-1:0] address0,
    input  logic [ADDR_WIDTH-1:0] address1,
    input  logic [ADDR_WIDTH-1:0] address2,
    input  logic [ADDR_WIDTH-1:0] address3,
    input  logic [DATA_WIDTH-1:0] input_data0,
    input  logic [DATA_WIDTH-1:0] input_data1,
    input  logic [DATA_WIDTH-1:0] input_data2,
    input  logic [DATA_WIDTH-1:0] input_data3,
    output logic [DATA_WIDTH-1:0] output_data0,
    output logic [DATA_WIDTH-1:0] output_data1,
    output logic [DATA_WIDTH-1:0] output_data2,
    output logic [DATA_WIDTH-1:0] output_data3
);

    import memory_pkg::*;

    // Per-client request bundles gathered into indexable form.
    logic [NUM_PORTS-1:0]  rd_vec;
    logic [NUM_PORTS-1:0]  wr_vec;
    logic [ADDR_WIDTH-1:0] addr_arr [NUM_PORTS];
    logic [DATA_WIDTH-1:0] din_arr  [NUM_PORTS];

    assign rd_vec      = {read3, read2, read1, read0};
    assign wr_vec      = {write3, write2, write1, write0};
    assign addr_arr[0] = address0;
    assign addr_arr[1] = address1;
    assign addr_arr[2] = address2;
    assign addr_arr[3] = address3;
    assign din_arr[0]  = input_data0;
    assign din_arr[1]  = input_data1;
    assign din_arr[2]  = input_data2;
    assign din_arr[3]  = input_data3;

    port_sel_t             sel;
    logic                  ram_we;
    logic                  ram_re;
    logic [ADDR_WIDTH-1:0] ram_addr;
    logic [DATA_WIDTH-1:0] ram_din;
    logic [DATA_WIDTH-1:0] ram_dout;

    assign sel = state;

    // 4:1 request mux; en gates both directions so a disabled cycle is a no-op.
    always_comb begin
        ram_we   = en & wr_vec[sel];
        ram_re   = en & rd_vec[sel];
        ram_addr = addr_arr[sel];
        ram_din  = din_arr[sel];
    end

    memory_array #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_memory_array (
        .clk  (clk),
        .rst  (rst),
        .we   (ram_we),
        .re   (ram_re),
        .addr (ram_addr),
        .din  (ram_din),
        .dout (ram_dout)
    );

    // Load enable per client: only the selected client's register may update.
    logic [NUM_PORTS-1:0] load_vec;

    generate
        for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_load
            assign load_vec[gi] = ram_re && (sel == port_sel_t'(gi));
        end
    endgenerate

    logic [DATA_WIDTH-1:0] out_q [NUM_PORTS];
    logic [DATA_WIDTH-1:0] out_d [NUM_PORTS];

    // Next-state for the read-data registers: capture RAM data or hold.
    always_comb begin
        for (int p = 0; p < NUM_PORTS; p++) begin
            out_d[p] = out_q[p];
            if (load_vec[p]) begin
                out_d[p] = ram_dout;
            end
        end
    end

    // Read-data registers, cleared asynchronously with the RAM.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                out_q[p] <= '0;
            end
        end else begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                out_q[p] <= out_d[p];
            end
        end
    end

    assign output_data0 = out_q[0];
    assign output_data1 = out_q[1];
    assign output_data2 = out_q[2];
    assign output_data3 = out_q[3];

endmodule : memory_controller

// File: tb/tb_memory_controller.sv
// Directed bench for memory_controller with a small RAM/output model and a
// scoreboard queue of expected read results.
module tb_memory_controller;

    logic       clk;
    logic       rst;
    logic       en;
    logic [1:0] state;
    logic       read0, read1, read2, read3;
    logic       write0, write1, write2, write3;
    logic [6:0] address0, address1, address2, address3;
    logic [7:0] input_data0, input_data1, input_data2, input_data3;
    logic [7:0] output_data0, output_data1, output_data2, output_data3;

    memory_controller dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .state        (state),
        .read0        (read0),
        .read1        (read1),
        .read2        (read2),
        .read3        (read3),
        .write0       (write0),
        .write1       (write1),
        .write2       (write2),
        .write3       (write3),
        .address0     (address0),
        .address1     (address1),
        .address2     (address2),
        .address3     (address3),
        .input_data0  (input_data0),
        .input_data1  (input_data1),
        .input_data2  (input_data2),
        .input_data3  (input_data3),
        .output_data0 (output_data0),
        .output_data1 (output_data1),
        .output_data2 (output_data2),
        .output_data3 (output_data3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [7:0] out_arr [4];
    assign out_arr[0] = output_data0;
    assign out_arr[1] = output_data1;
    assign out_arr[2] = output_data2;
    assign out_arr[3] = output_data3;

    typedef struct {
        int         port;
        logic [7:0] data;
    } sb_t;

    sb_t        sb_q [$];
    logic [7:0] model_mem [128];
    logic [7:0] model_out [4];
    int         checks = 0;
    int         errors = 0;

    task automatic check(input logic [7:0] obs, input logic [7:0] exp, input string tag);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        en = 1'b0; state = 2'd0;
        read0 = 0; read1 = 0; read2 = 0; read3 = 0;
        write0 = 0; write1 = 0; write2 = 0; write3 = 0;
        address0 = '0; address1 = '0; address2 = '0; address3 = '0;
        input_data0 = '0; input_data1 = '0; input_data2 = '0; input_data3 = '0;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 128; i++) model_mem[i] = 8'h00;
        for (int i = 0; i < 4; i++) model_out[i] = 8'h00;
        sb_q.delete();
    endtask

    // One clock: drive a single client's request, predict, then compare.
    task automatic step(input logic e, input logic [1:0] st, input int p,
                        input logic r, input logic w,
                        input logic [6:0] a, input logic [7:0] d, input string tag);
        sb_t item;
        @(negedge clk);
        clear_inputs();
        en = e;
        state = st;
        case (p)
            0: begin read0 = r; write0 = w; address0 = a; input_data0 = d; end
            1: begin read1 = r; write1 = w; address1 = a; input_data1 = d; end
            2: begin read2 = r; write2 = w; address2 = a; input_data2 = d; end
            default: begin read3 = r; write3 = w; address3 = a; input_data3 = d; end
        endcase
        if (e && (st == 2'(p))) begin
            if (r) begin
                item.port = p;
                item.data = model_mem[a];
                sb_q.push_back(item);
            end
            if (w) model_mem[a] = d;
        end
        @(posedge clk);
        #1;
        while (sb_q.size() > 0) begin
            item = sb_q.pop_front();
            model_out[item.port] = item.data;
            check(out_arr[item.port], item.data, {tag, "_rd"});
            $display("step %s: port%0d read addr=%0d data=%02h", tag, item.port, a, out_arr[item.port]);
        end
        for (int i = 0; i < 4; i++) begin
            check(out_arr[i], model_out[i], $sformatf("%s_hold%0d", tag, i));
        end
        clear_inputs();
    endtask

    initial begin
        clear_inputs();
        model_reset();
        rst = 1'b1;
        #1;
        for (int i = 0; i < 4; i++) check(out_arr[i], 8'h00, $sformatf("reset_out%0d", i));
        #12;
        @(negedge clk);
        rst = 1'b0;

        // Write via port 0, read back via port 1.
        step(1, 2'd0, 0, 0, 1, 7'd10, 8'd10, "wr0_a10");
        step(1, 2'd1, 1, 1, 0, 7'd10, 8'h00, "rd1_a10");

        // Non-selected client is ignored.
        step(1, 2'd2, 3, 0, 1, 7'd5, 8'hAA, "wr3_unsel");
        step(1, 2'd2, 2, 1, 0, 7'd5, 8'h00, "rd2_a5");

        // Enable gating: no write, no output update.
        step(0, 2'd0, 0, 0, 1, 7'd20, 8'h55, "wr0_en0");
        step(0, 2'd1, 1, 1, 0, 7'd10, 8'h00, "rd1_en0");
        step(1, 2'd0, 0, 1, 0, 7'd20, 8'h00, "rd0_a20");

        // Read-before-write on the same address.
        step(1, 2'd3, 3, 0, 1, 7'd7, 8'h11, "wr3_a7");
        step(1, 2'd3, 3, 1, 1, 7'd7, 8'h22, "rbw3_a7");
        step(1, 2'd1, 1, 1, 0, 7'd7, 8'h00, "rd1_a7");

        // Boundary addresses.
        step(1, 2'd2, 2, 0, 1, 7'd127, 8'hFF, "wr2_a127");
        step(1, 2'd2, 2, 0, 1, 7'd0, 8'h01, "wr2_a0");
        step(1, 2'd0, 0, 1, 0, 7'd127, 8'h00, "rd0_a127");
        step(1, 2'd0, 0, 1, 0, 7'd0, 8'h00, "rd0_a0");

        // Reset asserted mid-cycle clears outputs immediately, and the RAM too.
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        for (int i = 0; i < 4; i++) check(out_arr[i], 8'h00, $sformatf("midrst_out%0d", i));
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        step(1, 2'd2, 2, 1, 0, 7'd127, 8'h00, "rd2_after_rst");
        step(1, 2'd3, 3, 1, 0, 7'd7, 8'h00, "rd3_after_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_memory_controller
